// File: rtl/serial_frame_rx.sv
// serial_frame_rx: oversampling serial frame receiver that emits per-bit strobes for a shift buffer.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module serial_frame_rx #(
    parameter int unsigned NDATA = 128,
    parameter int unsigned OVS = 8,
    localparam int unsigned NDATA_LOG = $clog2(NDATA)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic                 dout,
    output logic                 ena,
    output logic [NDATA_LOG-1:0] cntout,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_err
);
    localparam int unsigned PW = $clog2(OVS);
    localparam logic [PW-1:0] PhCentre = PW'(OVS / 2 - 1);
    localparam logic [PW-1:0] PhVote = PW'(OVS / 2);
    localparam logic [PW-1:0] PhLast = PW'(OVS - 1);
    localparam logic [NDATA_LOG-1:0] CntLast = NDATA_LOG'(NDATA - 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e               state_q, state_d;
    logic                 sync_q, rxs_q;
    logic [1:0]           hist_q, flush_q;
    logic                 prev_q;
    logic [PW-1:0]        ph_q, ph_d;
    logic                 busy_q, busy_d;
    logic                 ena_q, ena_d;
    logic                 dout_q, dout_d;
    logic [NDATA_LOG-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 vote;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    // Majority of rxs over the three cycles ending at PhVote.
    assign vote = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sync_q  <= 1'b1;
            rxs_q   <= 1'b1;
            hist_q  <= 2'b11;
            flush_q <= 2'b00;
            prev_q  <= 1'b0;
            ph_q    <= '0;
            busy_q  <= 1'b0;
            ena_q   <= 1'b0;
            dout_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= rxd;
            rxs_q   <= sync_q;
            hist_q  <= {hist_q[0], rxs_q};
            flush_q <= {flush_q[0], 1'b1};
            // prev only reports high once the synchronizer holds real line data.
            prev_q  <= rxs_q & flush_q[1];
            ph_q    <= ph_d;
            busy_q  <= busy_d;
            ena_q   <= ena_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
        busy_d  = busy_q;
        ena_d   = 1'b0;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (prev_q && !rxs_q) begin
                    state_d = StStart;
                    ph_d    = '0;
                end
            end
            StStart: begin
                // Confirm at the start-bit centre, enter DATA one cycle later on the vote phase.
                if (ph_q == PhCentre) begin
                    if (rxs_q) begin
                        state_d = StIdle;
                    end else begin
                        busy_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                        par_d  = 1'b0;
                        perr_d = 1'b0;
`endif
                    end
                end else if (ph_q == PhVote) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (ph_q == PhVote) begin
                    ena_d  = 1'b1;
                    dout_d = vote;
`ifdef SERIAL_RX_PARITY_EN
                    par_d  = par_q ^ vote;
`endif
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            StParity: begin
                if (ph_q == PhVote) begin
                    perr_d  = par_q ^ vote;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (ph_q == PhVote) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
                    done_d  = vote & ~perr_q;
                    ferr_d  = ~vote | perr_q;
`else
                    done_d  = vote;
                    ferr_d  = ~vote;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dout       = dout_q;
    assign ena        = ena_q;
    assign cntout     = cnt_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: a precomputed line waveform plus an event-level model of expected outputs.
// Honours SERIAL_RX_PARITY_EN the same way as the design.
module tb_serial_frame_rx;
    localparam int unsigned NDATA = 8;
    localparam int unsigned OVS = 8;
    localparam int unsigned NL = $clog2(NDATA);
`ifdef SERIAL_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAT = 2 + OVS / 2 + OVS + 1;
    localparam int MAXC = 6000;

    logic clk = 1'b0;
    logic rst, rxd, dout, ena, busy, frame_done, frame_err;
    logic [NL-1:0] cntout;

    serial_frame_rx #(.NDATA(NDATA), .OVS(OVS)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .dout(dout), .ena(ena), .cntout(cntout),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    bit line_w [MAXC];
    bit rst_w  [MAXC];
    bit e_ena  [MAXC];
    bit e_dout [MAXC];
    bit e_done [MAXC];
    bit e_err  [MAXC];
    bit e_busy [MAXC];
    int e_cntv [MAXC];
    int e_cnt  [MAXC];
    int pos, cur_c, checks, errors;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, cur_c, act, exp);
        end
    endtask

    // Lays one frame on the line at pos and records the outputs it must produce.
    task automatic place(input logic [NDATA-1:0] data, input bit stop, input bit par_flip,
                         input int spike_bit, input int spike_off, input int abort_after,
                         output int t0);
        bit fb [NDATA+3];
        int nb, r, c;
        t0 = pos;
        nb = NDATA + P + 2;
        fb[0] = 1'b0;
        for (int k = 0; k < NDATA; k++) fb[k+1] = data[k];
        if (P == 1) fb[NDATA+1] = (^data) ^ par_flip;
        fb[NDATA+1+P] = stop;
        for (int i = 0; i < nb; i++)
            for (int o = 0; o < OVS; o++) line_w[t0 + i*OVS + o] = fb[i];
        if (spike_bit >= 0) begin
            c = t0 + (spike_bit + 1) * OVS + spike_off;
            line_w[c] = ~line_w[c];
        end
        r = (abort_after >= 0) ? t0 + LAT + OVS * (abort_after - 1) + 1 : MAXC;
        for (c = t0 + 2 + OVS/2; c < t0 + LAT + OVS*(NDATA+P); c++) if (c < r) e_busy[c] = 1'b1;
        for (int k = 0; k < NDATA; k++) begin
            c = t0 + LAT + OVS*k;
            if (c < r) begin
                e_ena[c] = 1'b1;
                e_dout[c] = data[k];
                e_cntv[c] = (k + 1) % NDATA;
            end
        end
        c = t0 + LAT + OVS*(NDATA+P);
        if (c < r) begin
            if (stop && !par_flip) e_done[c] = 1'b1;
            else e_err[c] = 1'b1;
        end
        if (abort_after >= 0) begin
            rst_w[r] = 1'b1;
            for (c = r; c < t0 + nb*OVS; c++) line_w[c] = 1'b1;
            pos = r + 8;
        end else begin
            pos = t0 + nb*OVS;
        end
    endtask

    int t_a5, t_3c, t_x, endc, cur;
    int n1, first1, done1, err3, done3;
    logic [7:0] byte1;

    initial begin
        checks = 0;
        errors = 0;
        for (int c = 0; c < MAXC; c++) line_w[c] = 1'b1;
        for (int c = 0; c < 4; c++) rst_w[c] = 1'b1;
        // Line held low through and after reset must not start a frame.
        for (int c = 0; c < 20; c++) line_w[c] = 1'b0;
        pos = 30;
        place(8'hA5, 1'b1, 1'b0, -1, 0, -1, t_a5);
        pos += 6;
        line_w[pos] = 1'b0;
        line_w[pos+1] = 1'b0;
        pos += 14;
        place(8'h3C, 1'b0, 1'b0, -1, 0, -1, t_3c);
        pos += 6;
        place(8'h5A, 1'b1, 1'b0, -1, 0, -1, t_x);
        pos += 6;
        place(8'hC3, 1'b1, 1'b0, 2, OVS/2, -1, t_x);
        pos += 6;
        place(8'h96, 1'b1, 1'b0, -1, 0, 4, t_x);
        place(8'hFF, 1'b1, 1'b0, -1, 0, -1, t_x);
        pos += 6;
        if (P == 1) begin
            place(8'h07, 1'b1, 1'b0, -1, 0, -1, t_x);
            pos += 6;
            place(8'h07, 1'b1, 1'b1, -1, 0, -1, t_x);
            pos += 6;
        end
        while (pos < MAXC - 300) begin
            if ($urandom_range(0, 5) == 0) begin
                line_w[pos] = 1'b0;
                line_w[pos+1] = 1'b0;
                pos += 14;
            end
            place($urandom, ($urandom_range(0, 4) != 0), (P == 1) && ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NDATA-1)) : -1,
                  $urandom_range(2, OVS-2), -1, t_x);
            pos += $urandom_range(4, 20);
        end
        endc = pos + 20;
        cur = 0;
        for (int c = 0; c < MAXC; c++) begin
            if (rst_w[c]) cur = 0;
            else if (e_ena[c]) cur = e_cntv[c];
            e_cnt[c] = cur;
        end

        n1 = 0; first1 = -1; done1 = 0; err3 = 0; done3 = 0; byte1 = 8'h00;
        rst = rst_w[0];
        rxd = line_w[0];
        for (int c = 0; c < endc; c++) begin
            @(posedge clk);
            #1;
            cur_c = c;
            chk("ena", int'(ena), int'(e_ena[c]));
            chk("frame_done", int'(frame_done), int'(e_done[c]));
            chk("frame_err", int'(frame_err), int'(e_err[c]));
            chk("busy", int'(busy), int'(e_busy[c]));
            chk("cntout", int'(cntout), e_cnt[c]);
            if (e_ena[c]) chk("dout", int'(dout), int'(e_dout[c]));
            if (c >= t_a5 && c < t_a5 + 90) begin
                if (ena) begin
                    if (first1 < 0) first1 = c - t_a5;
                    byte1 = {dout, byte1[7:1]};
                    n1++;
                end
                if (frame_done) done1++;
            end
            if (c >= t_3c && c < t_3c + 85) begin
                if (frame_err) err3++;
                if (frame_done) done3++;
            end
            rxd = line_w[c+1];
            rst = rst_w[c+1];
        end
        cur_c = endc;
        chk("a5_first_ena_latency", first1, 15);
        chk("a5_byte", int'(byte1), 8'hA5);
        chk("a5_ena_count", n1, 8);
        chk("a5_done_count", done1, 1);
        chk("3c_err_count", err3, 1);
        chk("3c_done_count", done3, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
